muldiv_requester: RTL and testbench
===================================

// Module: muldiv_requester
// PURPOSE
//  Initiator for the trigger/ready/done handshake of the multi-cycle multiplier and divider units.
//  - Accepts one arithmetic request at a time on a valid/ready port.
//  - Drives operands and trigger to the selected unit, then captures its result on done.
//  - Returns the result on a valid/ready response port.
//  - Sits between the synth control logic (phase-increment and envelope-rate calculation) and the shared multiplier/divider.
// PARAMETERS
//  C_WIDTH         32  operand/result width
//  TIMEOUT_CYCLES  64  WAIT_DONE cycle budget (used only with MULDIV_TIMEOUT_EN)
// PORTS
//  ctl_clk      in   1        clock; all logic on rising edge
//  reset        in   1        asynchronous, active-low reset
//  req_valid    in   1        request present
//  req_ready    out  1        requester idle; request accepted when req_valid&req_ready
//  req_op       in   1        0=multiply, 1=divide
//  req_signed   in   1        forwarded to unit signed_cal
//  req_a        in   C_WIDTH  operand a (dividend)
//  req_b        in   C_WIDTH  operand b (divisor)
//  op_a         out  C_WIDTH  registered operand a to both units
//  op_b         out  C_WIDTH  registered operand b to both units
//  op_signed    out  1        registered signed_cal to both units
//  mul_trigger  out  1        one-cycle start pulse to multiplier
//  mul_ready    in   1        multiplier idle
//  mul_done     in   1        one-cycle pulse; mul_y valid this cycle
//  mul_y        in   C_WIDTH  multiplier result
//  div_trigger  out  1        one-cycle start pulse to divider
//  div_ready    in   1        divider idle
//  div_done     in   1        one-cycle pulse; div_q/div_r valid this cycle
//  div_q        in   C_WIDTH  quotient
//  div_r        in   C_WIDTH  remainder
//  rsp_valid    out  1        response present
//  rsp_ready    in   1        consumer accepts response
//  rsp_lo       out  C_WIDTH  mul: y; div: q
//  rsp_hi       out  C_WIDTH  mul: 0; div: r
//  rsp_dz       out  1        divide-by-zero flag
//  rsp_err      out  1        timeout flag (tied 0 without MULDIV_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: every output 0, except req_ready=1; state IDLE. Mid-operation reset aborts the operation; a done arriving later is ignored.
//  IDLE:
//   - req_ready=1.
//   - On accept, latch op/signed/a/b into op_*, go ISSUE; req_ready falls the next cycle.
//  ISSUE:
//   - div with op_b==0: no trigger; rsp_lo=all ones, rsp_hi=op_a, rsp_dz=1; go RESP.
//   - Otherwise, if the selected unit's ready is high: assert its trigger for exactly this cycle, go WAIT_DONE.
//   - Otherwise stay in ISSUE.
//  WAIT_DONE:
//   - On selected done: capture result into rsp_lo/rsp_hi (rsp_hi=0 for mul), go RESP.
//   - done of the non-selected unit is ignored.
//  RESP:
//   - rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready, then go IDLE.
//   - rsp_valid, rsp_dz and rsp_err clear on that exit.
//  Latency: accept at cycle 0 -> trigger at cycle 1 (unit ready) -> rsp_valid the cycle after done.
//  Other rules:
//   - Strictly one outstanding operation; no request pipelining.
//   - op_a/op_b/op_signed are stable from trigger through done.
//   - done arriving in IDLE/ISSUE/RESP is ignored.
// CONFIGURATION
//  MULDIV_TIMEOUT_EN defined:
//   - Counter cleared on entering WAIT_DONE, incremented each cycle there.
//   - If no done before the count reaches TIMEOUT_CYCLES: go RESP with rsp_lo=rsp_hi=0, rsp_err=1.
//  Not defined: WAIT_DONE waits indefinitely; rsp_err constant 0; no counter logic.
// STRUCTURE
//  Shared package muldiv_pkg:
//   - OP_MUL=1'b0, OP_DIV=1'b1.
//   - State encoding IDLE/ISSUE/WAIT_DONE/RESP.
//  Sub-module op_watchdog (counter + expiry flag), instantiated only under MULDIV_TIMEOUT_EN.
// TESTING (C_WIDTH=32; FIXED_POINT=8 unit)
//  mul, unsigned, a=0x00000300, b=0x00000200 -> one mul_trigger pulse; rsp_lo=0x00000600, rsp_hi=0.
//  div, unsigned, a=100, b=7 -> one div_trigger pulse; rsp_lo=14, rsp_hi=2, rsp_dz=0.
//  div, a=5, b=0 -> no div_trigger; rsp_lo=0xFFFFFFFF, rsp_hi=5, rsp_dz=1 two cycles after accept.
//  rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready=0; accept on cycle 11, then IDLE.
//  div_ready=0 for 5 cycles -> no trigger until ready; then trigger; reset low in WAIT_DONE -> all outputs 0, late div_done ignored.
//  MULDIV_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never asserted -> rsp_valid=1 with rsp_err=1 after 16 WAIT_DONE cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module : muldiv_pkg
// Brief  : Shared opcode and state encodings for the mul/div requester.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

endpackage : muldiv_pkg

`default_nettype wire

// File: rtl/op_watchdog.sv
// ============================================================================
// Module : op_watchdog
// Brief  : Cycle counter that flags expiry after TIMEOUT_CYCLES enabled cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Saturates on the last count so a stalled state machine cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == c_LAST);

endmodule : op_watchdog

`default_nettype wire

// File: rtl/muldiv_requester.sv
// ============================================================================
// Module : muldiv_requester
// Brief  : Trigger/ready/done initiator for the shared multiplier and divider.
//          Optional WAIT_DONE timeout enabled by defining MULDIV_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_requester
  import muldiv_pkg::*;
#(
  parameter int C_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               ctl_clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_op,
  input  logic               req_signed,
  input  logic [C_WIDTH-1:0] req_a,
  input  logic [C_WIDTH-1:0] req_b,
  output logic [C_WIDTH-1:0] op_a,
  output logic [C_WIDTH-1:0] op_b,
  output logic               op_signed,
  output logic               mul_trigger,
  input  logic               mul_ready,
  input  logic               mul_done,
  input  logic [C_WIDTH-1:0] mul_y,
  output logic               div_trigger,
  input  logic               div_ready,
  input  logic               div_done,
  input  logic [C_WIDTH-1:0] div_q,
  input  logic [C_WIDTH-1:0] div_r,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [C_WIDTH-1:0] rsp_lo,
  output logic [C_WIDTH-1:0] rsp_hi,
  output logic               rsp_dz,
  output logic               rsp_err
);

  state_t r_state;
  state_t w_next;

  logic               r_op;
  logic [C_WIDTH-1:0] r_a;
  logic [C_WIDTH-1:0] r_b;
  logic               r_signed;
  logic [C_WIDTH-1:0] r_rsp_lo;
  logic [C_WIDTH-1:0] r_rsp_hi;
  logic               r_rsp_dz;

  logic w_accept;
  logic w_div_zero;
  logic w_sel_ready;
  logic w_sel_done;
  logic w_timeout;

  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_div_zero  = (r_op == OP_DIV) && (r_b == '0);
  assign w_sel_ready = (r_op == OP_DIV) ? div_ready : mul_ready;
  assign w_sel_done  = (r_op == OP_DIV) ? div_done  : mul_done;

`ifdef MULDIV_TIMEOUT_EN
  logic r_rsp_err;

  op_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (ctl_clk),
    .rst_n     (reset),
    .i_clear   (r_state == ST_ISSUE),
    .i_en      (r_state == ST_WAIT_DONE),
    .o_expired (w_timeout)
  );

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      r_rsp_err <= 1'b0;
    end else if ((r_state == ST_WAIT_DONE) && !w_sel_done && w_timeout) begin
      r_rsp_err <= 1'b1;
    end else if ((r_state == ST_RESP) && rsp_ready) begin
      r_rsp_err <= 1'b0;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout            = 1'b0;
  assign rsp_err              = 1'b0;
`endif

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_div_zero)       w_next = ST_RESP;
        else if (w_sel_ready) w_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_sel_done || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mul_trigger = 1'b0;
    div_trigger = 1'b0;
    case (r_state)
      ST_IDLE: req_ready = 1'b1;
      ST_ISSUE: begin
        if (!w_div_zero && w_sel_ready) begin
          mul_trigger = (r_op == OP_MUL);
          div_trigger = (r_op == OP_DIV);
        end
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands only load on accept, so they stay frozen from trigger through done.
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      r_op     <= OP_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_op     <= req_op;
      r_a      <= req_a;
      r_b      <= req_b;
      r_signed <= req_signed;
    end
  end

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      r_rsp_lo <= '0;
      r_rsp_hi <= '0;
      r_rsp_dz <= 1'b0;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_div_zero) begin
            r_rsp_lo <= '1;
            r_rsp_hi <= r_a;
            r_rsp_dz <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (w_sel_done) begin
            r_rsp_lo <= (r_op == OP_DIV) ? div_q : mul_y;
            r_rsp_hi <= (r_op == OP_DIV) ? div_r : '0;
          end else if (w_timeout) begin
            r_rsp_lo <= '0;
            r_rsp_hi <= '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_rsp_dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign op_a      = r_a;
  assign op_b      = r_b;
  assign op_signed = r_signed;
  assign rsp_lo    = r_rsp_lo;
  assign rsp_hi    = r_rsp_hi;
  assign rsp_dz    = r_rsp_dz;

endmodule : muldiv_requester

`default_nettype wire

// File: tb/tb_muldiv_requester.sv
// ============================================================================
// Module : tb_muldiv_requester
// Brief  : Directed self-checking bench for muldiv_requester (timeout case
//          only when MULDIV_TIMEOUT_EN is defined).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_requester;

  logic        ctl_clk = 1'b0;
  logic        reset;
  logic        req_valid, req_op, req_signed;
  logic [31:0] req_a, req_b;
  logic        req_ready;
  logic [31:0] op_a, op_b;
  logic        op_signed;
  logic        mul_trigger, mul_ready, mul_done;
  logic [31:0] mul_y;
  logic        div_trigger, div_ready, div_done;
  logic [31:0] div_q, div_r;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_dz, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ctl_clk = ~ctl_clk;

  muldiv_requester #(
    .C_WIDTH        (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ctl_clk     (ctl_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_signed  (req_signed),
    .req_a       (req_a),
    .req_b       (req_b),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_signed   (op_signed),
    .mul_trigger (mul_trigger),
    .mul_ready   (mul_ready),
    .mul_done    (mul_done),
    .mul_y       (mul_y),
    .div_trigger (div_trigger),
    .div_ready   (div_ready),
    .div_done    (div_done),
    .div_q       (div_q),
    .div_r       (div_r),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_lo      (rsp_lo),
    .rsp_hi      (rsp_hi),
    .rsp_dz      (rsp_dz),
    .rsp_err     (rsp_err)
  );

  task automatic step();
    @(negedge ctl_clk);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_signed = 1'b0;
    req_a = '0; req_b = '0; mul_ready = 1'b1; mul_done = 1'b0; mul_y = '0;
    div_ready = 1'b1; div_done = 1'b0; div_q = '0; div_r = '0; rsp_ready = 1'b0;

    // Reset state
    step(); step(); #1;
    chk1 ("rst_req_ready", req_ready, 1'b1);
    chk1 ("rst_rsp_valid", rsp_valid, 1'b0);
    chk1 ("rst_mul_trig",  mul_trigger, 1'b0);
    chk1 ("rst_div_trig",  div_trigger, 1'b0);
    chk32("rst_op_a",      op_a, 32'h0);
    chk32("rst_rsp_lo",    rsp_lo, 32'h0);
    chk1 ("rst_rsp_err",   rsp_err, 1'b0);
    step(); reset = 1'b1;

    // Multiply 0x300 * 0x200 (8-bit fixed point) -> 0x600
    step();
    req_valid = 1'b1; req_op = 1'b0; req_signed = 1'b0;
    req_a = 32'h0000_0300; req_b = 32'h0000_0200;
    #1 chk1("mul_req_ready", req_ready, 1'b1);
    step(); req_valid = 1'b0; #1;
    chk1 ("mul_trig_issue", mul_trigger, 1'b1);
    chk1 ("mul_no_div_trig", div_trigger, 1'b0);
    chk1 ("mul_req_ready_low", req_ready, 1'b0);
    chk32("mul_op_a", op_a, 32'h0000_0300);
    chk32("mul_op_b", op_b, 32'h0000_0200);
    step(); div_done = 1'b1; div_q = 32'hDEAD_BEEF; #1;
    chk1 ("mul_trig_once", mul_trigger, 1'b0);
    step(); div_done = 1'b0; mul_done = 1'b1; mul_y = 32'h0000_0600; #1;
    chk1 ("mul_other_done_ignored", rsp_valid, 1'b0);
    step(); mul_done = 1'b0; rsp_ready = 1'b1; #1;
    chk1 ("mul_rsp_valid", rsp_valid, 1'b1);
    chk32("mul_rsp_lo", rsp_lo, 32'h0000_0600);
    chk32("mul_rsp_hi", rsp_hi, 32'h0);
    chk1 ("mul_rsp_dz", rsp_dz, 1'b0);
    chk1 ("mul_rsp_err", rsp_err, 1'b0);
    step(); rsp_ready = 1'b0; #1;
    chk1 ("mul_exit_valid", rsp_valid, 1'b0);
    chk1 ("mul_exit_ready", req_ready, 1'b1);

    // Divide 100 / 7 -> q=14 r=2, with consumer back-pressure
    step();
    req_valid = 1'b1; req_op = 1'b1; req_signed = 1'b1;
    req_a = 32'd100; req_b = 32'd7;
    step(); req_valid = 1'b0; #1;
    chk1 ("div_trig_issue", div_trigger, 1'b1);
    chk1 ("div_no_mul_trig", mul_trigger, 1'b0);
    chk1 ("div_op_signed", op_signed, 1'b1);
    step(); div_done = 1'b1; div_q = 32'd14; div_r = 32'd2; #1;
    chk1 ("div_trig_once", div_trigger, 1'b0);
    step(); div_done = 1'b0; div_q = 32'hFFFF_0000; div_r = 32'h1234_5678; #1;
    chk1 ("div_rsp_valid", rsp_valid, 1'b1);
    chk32("div_rsp_lo", rsp_lo, 32'd14);
    chk32("div_rsp_hi", rsp_hi, 32'd2);
    chk1 ("div_rsp_dz", rsp_dz, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      chk1 ("hold_valid", rsp_valid, 1'b1);
      chk32("hold_lo", rsp_lo, 32'd14);
      chk32("hold_hi", rsp_hi, 32'd2);
      chk1 ("hold_req_ready", req_ready, 1'b0);
    end
    step(); rsp_ready = 1'b1; #1;
    chk1 ("hold_last_valid", rsp_valid, 1'b1);
    step(); rsp_ready = 1'b0; #1;
    chk1 ("hold_exit_valid", rsp_valid, 1'b0);
    chk1 ("hold_exit_ready", req_ready, 1'b1);

    // Divide by zero: no trigger, flagged response two cycles after accept
    step();
    req_valid = 1'b1; req_op = 1'b1; req_signed = 1'b0;
    req_a = 32'd5; req_b = 32'd0;
    step(); req_valid = 1'b0; #1;
    chk1 ("dz_no_trig", div_trigger, 1'b0);
    chk1 ("dz_not_yet_valid", rsp_valid, 1'b0);
    step(); #1;
    chk1 ("dz_rsp_valid", rsp_valid, 1'b1);
    chk32("dz_rsp_lo", rsp_lo, 32'hFFFF_FFFF);
    chk32("dz_rsp_hi", rsp_hi, 32'd5);
    chk1 ("dz_flag", rsp_dz, 1'b1);
    chk1 ("dz_no_trig_resp", div_trigger, 1'b0);
    rsp_ready = 1'b1;
    step(); rsp_ready = 1'b0; #1;
    chk1 ("dz_exit_valid", rsp_valid, 1'b0);
    chk1 ("dz_exit_flag", rsp_dz, 1'b0);
    chk1 ("dz_exit_ready", req_ready, 1'b1);

    // Divider busy for 5 cycles, then abort via reset in WAIT_DONE
    div_ready = 1'b0;
    step();
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd9; req_b = 32'd3;
    step(); req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("busy_no_trig", div_trigger, 1'b0);
      chk1("busy_req_ready", req_ready, 1'b0);
      step();
    end
    div_ready = 1'b1; #1;
    chk1 ("busy_trig", div_trigger, 1'b1);
    step(); reset = 1'b0; #1;
    chk1 ("abort_req_ready", req_ready, 1'b1);
    chk1 ("abort_rsp_valid", rsp_valid, 1'b0);
    chk1 ("abort_div_trig", div_trigger, 1'b0);
    chk32("abort_op_a", op_a, 32'h0);
    chk32("abort_op_b", op_b, 32'h0);
    chk32("abort_rsp_lo", rsp_lo, 32'h0);
    chk32("abort_rsp_hi", rsp_hi, 32'h0);
    chk1 ("abort_rsp_dz", rsp_dz, 1'b0);
    step(); div_done = 1'b1; div_q = 32'd3; div_r = 32'd0;
    step(); reset = 1'b1;
    step(); div_done = 1'b0; #1;
    chk1 ("late_done_valid", rsp_valid, 1'b0);
    chk1 ("late_done_ready", req_ready, 1'b1);
    chk32("late_done_lo", rsp_lo, 32'h0);

`ifdef MULDIV_TIMEOUT_EN
    // No done ever: timeout after 16 WAIT_DONE cycles
    step();
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd3; req_b = 32'd4;
    step(); req_valid = 1'b0; #1;
    chk1("tmo_trig", mul_trigger, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(); #1;
      chk1("tmo_waiting", rsp_valid, 1'b0);
    end
    step(); #1;
    chk1 ("tmo_rsp_valid", rsp_valid, 1'b1);
    chk1 ("tmo_rsp_err", rsp_err, 1'b1);
    chk32("tmo_rsp_lo", rsp_lo, 32'h0);
    chk32("tmo_rsp_hi", rsp_hi, 32'h0);
    rsp_ready = 1'b1;
    step(); rsp_ready = 1'b0; #1;
    chk1 ("tmo_exit_err", rsp_err, 1'b0);
    chk1 ("tmo_exit_valid", rsp_valid, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_muldiv_requester

`default_nettype wire
